// File: rtl/mem_responder.sv
// mem_responder: multi-cycle data-memory responder.
// Word read/write requests arrive over a valid/ready handshake and are answered
// in order after LATENCY pipeline stages; the response side can back-pressure.
// Optional feature macro: MEM_RESPONDER_ALIGN_CHECK_EN adds rsp_err and turns
// odd byte addresses into error responses that never touch the array.
//
// Handshake: a request is taken on a rising edge when req_valid && req_ready;
// a response is consumed on a rising edge when rsp_valid && rsp_ready. The
// requester holds its request stable while req_ready is low.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH_W = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [15:0] rsp_rdata
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int WORDS = 1 << DEPTH_W;

    // Word storage; deliberately not reset so contents survive rst_n.
    logic [15:0] r_mem [WORDS];

    // Response pipeline, index 0 = stage 1, index LATENCY-1 = output stage.
    logic        r_vld  [LATENCY];
    logic        r_wr   [LATENCY];
    logic [15:0] r_data [LATENCY];
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    logic        r_err  [LATENCY];
`endif

    logic               w_stall;
    logic               w_advance;
    logic               w_accept;
    logic               w_misaligned;
    logic               w_wr_en;
    logic [DEPTH_W-1:0] w_idx;
    logic [15:0]        w_stage1_data;
    logic               w_unused_addr;

    // The whole pipeline freezes only when the output entry cannot leave.
    assign w_stall   = r_vld[LATENCY-1] && !rsp_ready;
    assign w_advance = !w_stall;
    assign req_ready = w_advance;
    assign w_accept  = req_valid && w_advance;

    // Byte address to word index; upper bits drop out so addresses wrap.
    assign w_idx = req_addr[DEPTH_W:1];

    // Bits that may not reach the array are folded here so no bit is left dangling.
    assign w_unused_addr = ^req_addr;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign w_misaligned = req_addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_wr_en = w_accept && req_wr && !w_misaligned;

    // Write acks and error responses carry zero data; reads sample the array now.
    assign w_stage1_data = (req_wr || w_misaligned) ? 16'h0000 : r_mem[w_idx];

    // Array write on the accepting edge, so a read on the next edge sees it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= req_wdata;
        end
    end

    // Shift register of response entries; holds entirely on stall, bubbles kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_wr[i]   <= 1'b0;
                r_data[i] <= 16'h0000;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                r_err[i]  <= 1'b0;
`endif
            end
        end else if (w_advance) begin
            r_vld[0]  <= w_accept;
            r_wr[0]   <= w_accept && req_wr;
            r_data[0] <= w_accept ? w_stage1_data : 16'h0000;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
            r_err[0]  <= w_accept && w_misaligned;
`endif
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_wr[i]   <= r_wr[i-1];
                r_data[i] <= r_data[i-1];
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
                r_err[i]  <= r_err[i-1];
`endif
            end
        end
    end

    assign rsp_valid = r_vld[LATENCY-1];
    assign rsp_wr    = r_wr[LATENCY-1];
    assign rsp_rdata = r_data[LATENCY-1];
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    assign rsp_err   = r_err[LATENCY-1];
`endif

endmodule
